// File: rtl/uart_time_reporter_pkg.sv
// Shared constants for the UART time reporter: ASCII codes, FSM encoding and frame sizes.
package uart_time_reporter_pkg;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    localparam int unsigned FRAME_LEN_CRLF    = 13;
    localparam int unsigned FRAME_LEN_NO_CRLF = 11;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned BIN_W = 7;
    localparam int unsigned BCD_W = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_SEND      = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_FIN       = 3'd4;

    function automatic logic [7:0] ascii_digit(input logic [BCD_W-1:0] d);
        return ASC_0 + 8'(d);
    endfunction

endpackage

// File: rtl/uart_time_reporter_bin2bcd_99.sv
// Combinational 7-bit binary to two BCD digits; anything above 99 reads as 99.
module bin2bcd_99
    import uart_time_reporter_pkg::*;
(
    input  logic [BIN_W-1:0] i_bin,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_ones
);

    logic [BIN_W-1:0] rem_c;

    // Compare ladder instead of a divider: the largest multiple of ten not above the input wins.
    always_comb begin
        o_tens = '0;
        rem_c  = i_bin;
        if (i_bin > BIN_W'(99)) begin
            o_tens = BCD_W'(9);
            rem_c  = BIN_W'(9);
        end else begin
            for (int unsigned k = 1; k <= 9; k++) begin
                if (i_bin >= BIN_W'(10 * k)) begin
                    o_tens = BCD_W'(k);
                    rem_c  = i_bin - BIN_W'(10 * k);
                end
            end
        end
        o_ones = BCD_W'(rem_c);
    end

endmodule

// File: rtl/uart_time_reporter.sv
// Snapshots the time on a report request and streams "HH:MM:SS.CC[CR LF]" to a byte UART transmitter.
module uart_time_reporter
    import uart_time_reporter_pkg::*;
#(
    parameter logic SEND_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_report,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [6:0] i_csec,
    input  logic       i_tx_busy,
    input  logic       i_tx_done,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = SEND_CRLF ? IDX_W'(FRAME_LEN_CRLF - 1)
                                                      : IDX_W'(FRAME_LEN_NO_CRLF - 1);

    logic [2:0]       state_q, state_d;
    logic             report_q, report_d;
    logic             pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [4:0]       hour_q, hour_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic [6:0]       csec_q, csec_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic             req_c;
    logic [7:0]       char_c;
    logic [BCD_W-1:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o, csec_t, csec_o;

    bin2bcd_99 u_bcd_hour (.i_bin(BIN_W'(hour_q)), .o_tens(hour_t), .o_ones(hour_o));
    bin2bcd_99 u_bcd_min  (.i_bin(BIN_W'(min_q)),  .o_tens(min_t),  .o_ones(min_o));
    bin2bcd_99 u_bcd_sec  (.i_bin(BIN_W'(sec_q)),  .o_tens(sec_t),  .o_ones(sec_o));
    bin2bcd_99 u_bcd_csec (.i_bin(BIN_W'(csec_q)), .o_tens(csec_t), .o_ones(csec_o));

    assign req_c = i_report & ~report_q;

    // Character for the current byte position, always taken from the snapshot.
    always_comb begin
        char_c = ASC_LF;
        case (idx_q)
            4'd0:    char_c = ascii_digit(hour_t);
            4'd1:    char_c = ascii_digit(hour_o);
            4'd2:    char_c = ASC_COLON;
            4'd3:    char_c = ascii_digit(min_t);
            4'd4:    char_c = ascii_digit(min_o);
            4'd5:    char_c = ASC_COLON;
            4'd6:    char_c = ascii_digit(sec_t);
            4'd7:    char_c = ascii_digit(sec_o);
            4'd8:    char_c = ASC_DOT;
            4'd9:    char_c = ascii_digit(csec_t);
            4'd10:   char_c = ascii_digit(csec_o);
            4'd11:   char_c = ASC_CR;
            default: char_c = ASC_LF;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        report_d     = i_report;
        pending_d    = pending_q;
        idx_d        = idx_q;
        hour_d       = hour_q;
        min_d        = min_q;
        sec_d        = sec_q;
        csec_d       = csec_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_c) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (req_c) pending_d = 1'b1;
                hour_d  = i_hour;
                min_d   = i_min;
                sec_d   = i_sec;
                csec_d  = i_csec;
                idx_d   = '0;
                busy_d  = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (req_c) pending_d = 1'b1;
                if (!i_tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = char_c;
                    state_d    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (req_c) pending_d = 1'b1;
                if (i_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = ST_FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            ST_FIN: begin
                // A request landing in this very cycle is served just like a latched one.
                if (pending_q || req_c) begin
                    pending_d = 1'b0;
                    state_d   = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            report_q     <= 1'b0;
            pending_q    <= 1'b0;
            idx_q        <= '0;
            hour_q       <= '0;
            min_q        <= '0;
            sec_q        <= '0;
            csec_q       <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            report_q     <= report_d;
            pending_q    <= pending_d;
            idx_q        <= idx_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            csec_q       <= csec_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_tx_start   = tx_start_q;
    assign o_tx_data    = tx_data_q;
    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_time_reporter.sv
// Bench for uart_time_reporter: transmitter models with a byte scoreboard, both frame formats.
module tb_uart_time_reporter;

    localparam int LAT    = 20;
    localparam int BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       report_a, report_b;
    logic [4:0] hour;
    logic [5:0] min, sec;
    logic [6:0] csec;
    logic       force_busy;
    logic       busy_a, done_a, busy_b, done_b;
    logic       tx_busy_a;
    logic       start_a, obusy_a, fd_a, start_b, obusy_b, fd_b;
    logic [7:0] data_a, data_b;

    int checks = 0;
    int errors = 0;
    int starts_a = 0, starts_b = 0, fds_a = 0, fds_b = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic       act_a = 1'b0, act_b = 1'b0, abort_a = 1'b0, abort_b = 1'b0;
    int         cnt_a = 0, cnt_b = 0;
    logic [7:0] held_a = 8'h00, held_b = 8'h00;

    always #5 clk = ~clk;

    assign tx_busy_a = busy_a | force_busy;

    uart_time_reporter #(.SEND_CRLF(1'b1)) dut_a (
        .clk(clk), .rst(rst), .i_report(report_a),
        .i_hour(hour), .i_min(min), .i_sec(sec), .i_csec(csec),
        .i_tx_busy(tx_busy_a), .i_tx_done(done_a),
        .o_tx_start(start_a), .o_tx_data(data_a), .o_busy(obusy_a), .o_frame_done(fd_a)
    );

    uart_time_reporter #(.SEND_CRLF(1'b0)) dut_b (
        .clk(clk), .rst(rst), .i_report(report_b),
        .i_hour(hour), .i_min(min), .i_sec(sec), .i_csec(csec),
        .i_tx_busy(busy_b), .i_tx_done(done_b),
        .o_tx_start(start_b), .o_tx_data(data_b), .o_busy(obusy_b), .o_frame_done(fd_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dig_t(input int v);
        return (v >= 100) ? 8'h39 : 8'h30 + 8'(v / 10);
    endfunction

    function automatic logic [7:0] dig_o(input int v);
        return (v >= 100) ? 8'h39 : 8'h30 + 8'(v % 10);
    endfunction

    task automatic push_frame(input int k, input int h, input int m, input int s, input int cs,
                              input bit crlf);
        logic [7:0] f [13];
        int n;
        f = '{dig_t(h), dig_o(h), 8'h3A, dig_t(m), dig_o(m), 8'h3A, dig_t(s), dig_o(s),
              8'h2E, dig_t(cs), dig_o(cs), 8'h0D, 8'h0A};
        n = crlf ? 13 : 11;
        for (int i = 0; i < n; i++) begin
            if (k == 0) q_a.push_back(f[i]);
            else        q_b.push_back(f[i]);
        end
    endtask

    // Transmitter model A: every start pops the scoreboard; done pulses LAT cycles later.
    always @(negedge clk) begin
        logic [7:0] e;
        done_a = 1'b0;
        if (rst) abort_a = 1'b1;
        if (start_a === 1'b1) begin
            starts_a++;
            chk("a_start_while_tx_busy", 32'(act_a), 0);
            chk("a_start_with_bytes_expected", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                chk("a_byte", 32'(data_a), 32'(e));
            end
            held_a  = data_a;
            act_a   = 1'b1;
            abort_a = 1'b0;
            cnt_a   = 0;
        end else if (act_a) begin
            if (!abort_a) chk("a_data_stable", 32'(data_a), 32'(held_a));
            cnt_a++;
            if (cnt_a == LAT) begin
                done_a = 1'b1;
                act_a  = 1'b0;
            end
        end
        if (fd_a === 1'b1) begin
            fds_a++;
            chk("a_busy_low_with_frame_done", 32'(obusy_a), 0);
        end
        busy_a = act_a;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        done_b = 1'b0;
        if (rst) abort_b = 1'b1;
        if (start_b === 1'b1) begin
            starts_b++;
            chk("b_start_while_tx_busy", 32'(act_b), 0);
            chk("b_start_with_bytes_expected", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                chk("b_byte", 32'(data_b), 32'(e));
            end
            held_b  = data_b;
            act_b   = 1'b1;
            abort_b = 1'b0;
            cnt_b   = 0;
        end else if (act_b) begin
            if (!abort_b) chk("b_data_stable", 32'(data_b), 32'(held_b));
            cnt_b++;
            if (cnt_b == LAT) begin
                done_b = 1'b1;
                act_b  = 1'b0;
            end
        end
        if (fd_b === 1'b1) begin
            fds_b++;
            chk("b_busy_low_with_frame_done", 32'(obusy_b), 0);
        end
        busy_b = act_b;
    end

    task automatic wait_fd(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((k == 0) ? fd_a : fd_b) !== 1'b1 && n < BUDGET);
        chk((k == 0) ? "a_frame_done_seen" : "b_frame_done_seen",
            32'((k == 0) ? fd_a : fd_b), 1);
    endtask

    task automatic wait_starts_a(input int target);
        int n = 0;
        while (starts_a < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("a_start_count_reached", 32'(starts_a >= target), 1);
    endtask

    task automatic pulse_a();
        @(negedge clk) report_a = 1'b1;
        @(negedge clk) report_a = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, f0, n;
        logic saw;
        rst = 1'b1; report_a = 1'b0; report_b = 1'b0; force_busy = 1'b0;
        busy_a = 1'b0; done_a = 1'b0; busy_b = 1'b0; done_b = 1'b0;
        hour = 5'd0; min = 6'd0; sec = 6'd0; csec = 7'd0;
        repeat (3) @(negedge clk);
        chk("rst_a_start", 32'(start_a), 0);
        chk("rst_a_data", 32'(data_a), 0);
        chk("rst_a_busy", 32'(obusy_a), 0);
        chk("rst_a_frame_done", 32'(fd_a), 0);
        chk("rst_b_start", 32'(start_b), 0);
        chk("rst_b_data", 32'(data_b), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 12:34:56.78 with CR LF, plus request-to-start latency.
        hour = 5'd12; min = 6'd34; sec = 6'd56; csec = 7'd78;
        push_frame(0, 12, 34, 56, 78, 1);
        s0 = starts_a; f0 = fds_a;
        report_a = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            report_a = 1'b0;
            n++;
        end while (start_a !== 1'b1 && n < 50);
        chk("a_request_to_start_latency", 32'(n), 3);
        chk("a_busy_during_frame", 32'(obusy_a), 1);
        wait_fd(0);
        repeat (2) @(negedge clk);
        chk("a_starts_crlf_frame", 32'(starts_a - s0), 13);
        chk("a_frame_done_pulses", 32'(fds_a - f0), 1);
        chk("a_busy_after_frame", 32'(obusy_a), 0);
        chk("a_queue_drained", 32'(q_a.size()), 0);

        // 00:00:00.00 without CR LF.
        hour = 5'd0; min = 6'd0; sec = 6'd0; csec = 7'd0;
        push_frame(1, 0, 0, 0, 0, 0);
        s0 = starts_b; f0 = fds_b;
        @(negedge clk) report_b = 1'b1;
        @(negedge clk) report_b = 1'b0;
        wait_fd(1);
        repeat (2) @(negedge clk);
        chk("b_starts_short_frame", 32'(starts_b - s0), 11);
        chk("b_frame_done_pulses", 32'(fds_b - f0), 1);
        chk("b_queue_drained", 32'(q_b.size()), 0);

        // Saturation and snapshot isolation: seconds change after the first byte.
        hour = 5'd7; min = 6'd63; sec = 6'd5; csec = 7'd120;
        push_frame(0, 7, 63, 5, 120, 1);
        s0 = starts_a;
        pulse_a();
        wait_starts_a(s0 + 1);
        sec = 6'd9;
        wait_fd(0);
        repeat (2) @(negedge clk);
        chk("a_starts_clamp_frame", 32'(starts_a - s0), 13);
        chk("a_queue_drained_clamp", 32'(q_a.size()), 0);

        // Transmitter busy for 50 cycles when the request arrives.
        hour = 5'd23; min = 6'd59; sec = 6'd59; csec = 7'd99;
        push_frame(0, 23, 59, 59, 99, 1);
        s0 = starts_a;
        force_busy = 1'b1;
        report_a = 1'b1;
        saw = 1'b0;
        repeat (50) begin
            @(negedge clk);
            report_a = 1'b0;
            saw = saw | start_a;
        end
        chk("a_no_start_while_busy", 32'(saw), 0);
        force_busy = 1'b0;
        @(negedge clk);
        chk("a_start_one_cycle_after_busy_falls", 32'(start_a), 1);
        wait_fd(0);
        repeat (2) @(negedge clk);
        chk("a_starts_busy_frame", 32'(starts_a - s0), 13);

        // Three requests during a frame yield exactly one extra frame with a fresh snapshot.
        hour = 5'd1; min = 6'd2; sec = 6'd3; csec = 7'd4;
        push_frame(0, 1, 2, 3, 4, 1);
        s0 = starts_a; f0 = fds_a;
        pulse_a();
        wait_starts_a(s0 + 1);
        repeat (3) pulse_a();
        hour = 5'd21; min = 6'd43; sec = 6'd9; csec = 7'd99;
        push_frame(0, 21, 43, 9, 99, 1);
        wait_fd(0);
        wait_fd(0);
        repeat (300) @(negedge clk);
        chk("a_starts_two_frames", 32'(starts_a - s0), 26);
        chk("a_frame_done_two_frames", 32'(fds_a - f0), 2);
        chk("a_queue_drained_pending", 32'(q_a.size()), 0);

        // Request landing in the frame-done cycle is served.
        hour = 5'd4; min = 6'd5; sec = 6'd6; csec = 7'd7;
        push_frame(0, 4, 5, 6, 7, 1);
        s0 = starts_a;
        pulse_a();
        wait_fd(0);
        report_a = 1'b1;
        hour = 5'd10; min = 6'd20; sec = 6'd30; csec = 7'd40;
        push_frame(0, 10, 20, 30, 40, 1);
        @(negedge clk) report_a = 1'b0;
        wait_fd(0);
        repeat (2) @(negedge clk);
        chk("a_starts_fin_request", 32'(starts_a - s0), 26);
        chk("a_queue_drained_fin", 32'(q_a.size()), 0);

        // Reset during byte 5, then a clean frame.
        hour = 5'd12; min = 6'd34; sec = 6'd56; csec = 7'd78;
        push_frame(0, 12, 34, 56, 78, 1);
        s0 = starts_a;
        pulse_a();
        wait_starts_a(s0 + 5);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_start", 32'(start_a), 0);
        chk("mid_rst_data", 32'(data_a), 0);
        chk("mid_rst_busy", 32'(obusy_a), 0);
        chk("mid_rst_frame_done", 32'(fd_a), 0);
        @(negedge clk) rst = 1'b0;
        q_a.delete();
        s0 = starts_a; f0 = fds_a;
        repeat (100) @(negedge clk);
        chk("a_no_starts_after_reset", 32'(starts_a - s0), 0);
        chk("a_no_frame_done_after_reset", 32'(fds_a - f0), 0);
        chk("a_idle_after_reset", 32'(obusy_a), 0);
        hour = 5'd8; min = 6'd9; sec = 6'd10; csec = 7'd11;
        push_frame(0, 8, 9, 10, 11, 1);
        pulse_a();
        wait_fd(0);
        repeat (2) @(negedge clk);
        chk("a_starts_after_reset_frame", 32'(starts_a - s0), 13);
        chk("a_queue_drained_after_reset", 32'(q_a.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
